bin_div_seq: RTL

//  Parametrised sequential restoring divider; successor to the 16-bit combinational divider.

---
 rtl/bin_div_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bin_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned or
// two's-complement operands, start/busy/done handshake.
module bin_div_seq #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    // state | meaning
    // IDLE  | waiting for start; operands latched on acceptance
    // CALC  | one restoring step per cycle, WIDTH steps
    // FIX   | sign fix-up, publish results, pulse done
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic busy_nxt, done_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   dvs_mag;
    logic             neg_q, neg_r, dbz_r, ovf_r;

    logic             signed_eff, dvd_neg, dvs_neg, dvs_zero, ovf_case;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH:0]   dvs_mag_in;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

    assign signed_eff = SIGNED_EN & signed_mode;
    assign dvd_neg    = signed_eff & dividend[WIDTH-1];
    assign dvs_neg    = signed_eff & divisor[WIDTH-1];
    assign dvs_zero   = (divisor == '0);
    assign dvd_mag    = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag_in = dvs_neg ? ({1'b0, ~divisor} + 1'b1) : {1'b0, divisor};
    assign ovf_case   = signed_eff && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                        && (divisor == '1);

    // Shifted partial remainder minus divisor; the top bit is the borrow.
    assign trial    = {rem, quo[WIDTH-1]} - {1'b0, dvs_mag};
    assign trial_ok = ~trial[WIDTH+1];

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_nxt  = 1'b1;
                    state_nxt = dvs_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs_mag <= dvs_mag_in;
                        neg_q   <= dvd_neg ^ dvs_neg;
                        neg_r   <= dvd_neg;
                        dbz_r   <= dvs_zero;
                        ovf_r   <= ovf_case;
                        cnt     <= CW'(WIDTH - 1);
                        // Divide by zero skips CALC; rem carries the raw dividend through.
                        if (dvs_zero) begin
                            rem <= {1'b0, dividend};
                            quo <= '0;
                        end else begin
                            rem <= '0;
                            quo <= dvd_mag;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    rem <= trial_ok ? trial[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
                end
                FIX: begin
                    if (dbz_r) begin
                        quotient  <= '1;
                        remainder <= rem[WIDTH-1:0];
                    end else begin
                        quotient  <= neg_q ? -quo : quo;
                        remainder <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                    div_by_zero <= dbz_r;
                    overflow    <= ovf_r;
                end
                default: ;
            endcase
        end
    end

endmodule
